// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : uart_pkg
//  Description : Constants shared by uart_rx, uart_tx and uart_rx_fifo.
//                UART_DATA_W - byte width on the serial link
//                UART_CR     - carriage-return code that marks a line end
//                BIT_RATE    - serial bit rate in bits per second
//                CLK_HZ      - system clock frequency in Hz
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;
    localparam logic [7:0]  UART_CR     = 8'h0D;
    localparam int unsigned BIT_RATE    = 115_200;
    localparam int unsigned CLK_HZ      = 50_000_000;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Interface   : uart_rx_fifo_if
//  Description : Write strobe, read handshake and status bundle of the
//                receive FIFO.
//                master : producer/consumer side (uart_rx + uart_tx)
//                slave  : FIFO side
//  Signals     : wr_valid_i, wr_data_i  - write strobe and byte
//                rd_valid_i             - head byte consumed
//                rd_ready_o, rd_data_o  - head byte available / value
//                full_o, empty_o,
//                count_o, overflow_o    - status
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic                wr_valid_i;
    logic [DATA_W-1:0]   wr_data_i;
    logic                rd_valid_i;
    logic                rd_ready_o;
    logic [DATA_W-1:0]   rd_data_o;
    logic                full_o;
    logic                empty_o;
    logic [c_CNT_W-1:0]  count_o;
    logic                overflow_o;

    modport master (
        output wr_valid_i, wr_data_i, rd_valid_i,
        input  rd_ready_o, rd_data_o, full_o, empty_o, count_o, overflow_o
    );

    modport slave (
        input  wr_valid_i, wr_data_i, rd_valid_i,
        output rd_ready_o, rd_data_o, full_o, empty_o, count_o, overflow_o
    );

endinterface : uart_rx_fifo_if
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : uart_fifo_mem
//  Description : Simple dual-port register array, DEPTH x DATA_W.
//                Synchronous write, asynchronous read, no reset.
//  Ports       : clk_i      - clock
//                wr_en_i    - write enable
//                wr_addr_i  - write address
//                wr_data_i  - write data
//                rd_addr_i  - read address
//                rd_data_o  - read data (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                       clk_i,
    input  logic                       wr_en_i,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr_i,
    output logic [DATA_W-1:0]          rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule : uart_fifo_mem
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : First-word-fall-through byte FIFO between uart_rx and
//                uart_tx. Bytes are written with a one-cycle strobe; the
//                head byte is offered with rd_ready_o and consumed by a
//                one-cycle rd_valid_i pulse. Reports count, full, empty
//                and a sticky overflow flag (set when a write is dropped).
//  Ports       : clk_i      - clock, rising edge
//                nreset_i   - synchronous active-low reset
//                bus        - uart_rx_fifo_if.slave (strobe, handshake,
//                             status)
//  Options     : UART_FIFO_LINE_MODE_EN - when defined, the head byte is
//                only offered once a complete line (terminated by CR) is
//                stored, or when the FIFO is full.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic           clk_i,
    input  logic           nreset_i,
    uart_rx_fifo_if.slave  bus
);

    localparam int                 c_ADDR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W  = c_ADDR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH  = c_CNT_W'(DEPTH);

    logic [c_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0]  count_q,  count_d;
    logic                full_q,   full_d;
    logic                empty_q,  empty_d;
    logic                overflow_q, overflow_d;

    logic                w_rd_ready;
    logic                w_push;
    logic                w_pop;
    logic [DATA_W-1:0]   w_mem_rd;

`ifdef UART_FIFO_LINE_MODE_EN
    logic [c_CNT_W-1:0]  lines_q, lines_d;
    logic                w_push_cr;
    logic                w_pop_cr;

    // Full escape: without it a CR-less stream would block forever.
    assign w_rd_ready = !empty_q && ((lines_q != '0) || full_q);
    assign w_push_cr  = w_push && (bus.wr_data_i == DATA_W'(UART_CR));
    assign w_pop_cr   = w_pop  && (w_mem_rd      == DATA_W'(UART_CR));
    assign lines_d    = lines_q + c_CNT_W'(w_push_cr) - c_CNT_W'(w_pop_cr);
`else
    assign w_rd_ready = !empty_q;
`endif

    assign w_pop  = bus.rd_valid_i && w_rd_ready;
    // A pop in the same cycle frees the slot, so a write to a full FIFO
    // is accepted when it coincides with a pop.
    assign w_push = bus.wr_valid_i && (!full_q || w_pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d    = count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        full_d     = (count_d == c_DEPTH);
        empty_d    = (count_d == '0);
        overflow_d = overflow_q || (bus.wr_valid_i && !w_push);
    end

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
`ifdef UART_FIFO_LINE_MODE_EN
            lines_q    <= '0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
`ifdef UART_FIFO_LINE_MODE_EN
            lines_q    <= lines_d;
`endif
        end
    end

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk_i     (clk_i),
        .wr_en_i   (w_push),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (bus.wr_data_i),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (w_mem_rd)
    );

    // Stale memory contents stay hidden whenever nothing is offered.
    assign bus.rd_data_o  = w_rd_ready ? w_mem_rd : '0;
    assign bus.rd_ready_o = w_rd_ready;
    assign bus.full_o     = full_q;
    assign bus.empty_o    = empty_q;
    assign bus.count_o    = count_q;
    assign bus.overflow_o = overflow_q;

endmodule : uart_rx_fifo
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Self-checking bench for uart_rx_fifo. A queue-based model
//                predicts every output each cycle; directed sequences add
//                literal expectations on the drained byte stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int DW    = 8;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DEPTH(DEPTH), .DATA_W(DW)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk_i    (clk),
        .nreset_i (nreset),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;
    int max_cnt  = 0;

    logic [7:0] mq[$];   // model contents, head at index 0
    bit         m_ovf;
    logic [7:0] log_q[$]; // bytes the DUT handed over on each accepted pop

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit m_ready();
`ifdef UART_FIFO_LINE_MODE_EN
        int crs = 0;
        foreach (mq[i]) if (mq[i] == 8'h0D) crs++;
        return (mq.size() != 0) && (crs != 0 || mq.size() == DEPTH);
`else
        return mq.size() != 0;
`endif
    endfunction

    // Model update on each rising edge from the inputs presented that cycle.
    always @(posedge clk) begin : model_upd
        bit pop, push;
        if (!nreset) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            pop  = bus.rd_valid_i && m_ready();
            push = bus.wr_valid_i && (mq.size() < DEPTH || pop);
            if (bus.wr_valid_i && !push) m_ovf = 1'b1;
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(bus.wr_data_i);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin : compare
        bit er;
        if (cmp_en) begin
            er = m_ready();
            chk("rd_ready", bus.rd_ready_o, er);
            chk("rd_data",  bus.rd_data_o,  er ? mq[0] : 8'h00);
            chk("count",    bus.count_o,    mq.size());
            chk("full",     bus.full_o,     mq.size() == DEPTH);
            chk("empty",    bus.empty_o,    mq.size() == 0);
            chk("overflow", bus.overflow_o, m_ovf);
            if (int'(bus.count_o) > max_cnt) max_cnt = int'(bus.count_o);
        end
    end

    // One clock cycle of stimulus; records the head byte on accepted pops.
    task automatic cycle(input bit wv, input logic [7:0] wd, input bit rv);
        bus.wr_valid_i = wv;
        bus.wr_data_i  = wd;
        bus.rd_valid_i = rv;
        #1;
        if (rv && bus.rd_ready_o) log_q.push_back(bus.rd_data_o);
        @(posedge clk);
        #1;
        bus.wr_valid_i = 1'b0;
        bus.rd_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        cycle(0, 8'h00, 0);
        cycle(0, 8'h00, 0);
        nreset = 1'b1;
    endtask

    initial begin
        bus.wr_valid_i = 1'b0;
        bus.wr_data_i  = 8'h00;
        bus.rd_valid_i = 1'b0;
        @(posedge clk);
        #1;
        cmp_en = 1'b1;
        do_reset();

        // Reset state
        chk("rst_empty",    bus.empty_o,    1);
        chk("rst_count",    bus.count_o,    0);
        chk("rst_ready",    bus.rd_ready_o, 0);
        chk("rst_data",     bus.rd_data_o,  8'h00);
        chk("rst_overflow", bus.overflow_o, 0);

`ifdef UART_FIFO_LINE_MODE_EN
        cycle(1, 8'h68, 0);
        cycle(1, 8'h69, 0);
        chk("line_no_cr_ready", bus.rd_ready_o, 0);
        cycle(1, 8'h0D, 0);
        chk("line_cr_ready", bus.rd_ready_o, 1);
        log_q.delete();
        repeat (3) cycle(0, 8'h00, 1);
        chk("line_n",  log_q.size(), 3);
        chk("line_b0", log_q[0], 8'h68);
        chk("line_b1", log_q[1], 8'h69);
        chk("line_b2", log_q[2], 8'h0D);
        chk("line_drained_ready", bus.rd_ready_o, 0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("line_15_ready", bus.rd_ready_o, 0);
            cycle(1, 8'(8'h20 + i), 0);
        end
        chk("line_full", bus.full_o, 1);
        chk("line_full_ready", bus.rd_ready_o, 1);
`else
        // Basic push / fall-through / pop
        cycle(1, 8'h41, 0);
        chk("first_ready", bus.rd_ready_o, 1);
        chk("first_data",  bus.rd_data_o,  8'h41);
        cycle(1, 8'h42, 0);
        cycle(1, 8'h43, 0);
        log_q.delete();
        repeat (3) cycle(0, 8'h00, 1);
        chk("abc_n",  log_q.size(), 3);
        chk("abc_b0", log_q[0], 8'h41);
        chk("abc_b1", log_q[1], 8'h42);
        chk("abc_b2", log_q[2], 8'h43);
        chk("abc_empty", bus.empty_o, 1);
        cycle(0, 8'h00, 1);   // pop on empty is ignored
        chk("empty_pop_count", bus.count_o, 0);

        // Fill, overflow, drain
        for (int i = 0; i < 16; i++) cycle(1, 8'(i), 0);
        chk("fill_full",  bus.full_o,  1);
        chk("fill_count", bus.count_o, 16);
        cycle(1, 8'hFF, 0);
        chk("ovf_set",   bus.overflow_o, 1);
        chk("ovf_count", bus.count_o,    16);
        log_q.delete();
        repeat (16) cycle(0, 8'h00, 1);
        chk("drain_n", log_q.size(), 16);
        for (int i = 0; i < 16; i++) chk("drain_byte", log_q[i], 8'(i));
        chk("ovf_sticky", bus.overflow_o, 1);

        // Simultaneous push and pop while full
        do_reset();
        chk("rst2_overflow", bus.overflow_o, 0);
        for (int i = 0; i < 16; i++) cycle(1, 8'(8'h10 + i), 0);
        log_q.delete();
        cycle(1, 8'hAA, 1);
        chk("pp_full_count", bus.count_o,    16);
        chk("pp_full_ovf",   bus.overflow_o, 0);
        repeat (16) cycle(0, 8'h00, 1);
        chk("pp_n",     log_q.size(), 17);
        chk("pp_first", log_q[0],  8'h10);
        chk("pp_last",  log_q[16], 8'hAA);

        // Mid-operation reset, then pointer wrap with paired push/pop
        cycle(1, 8'h55, 0);
        cycle(1, 8'h66, 0);
        do_reset();
        chk("mid_rst_count", bus.count_o,   0);
        chk("mid_rst_data",  bus.rd_data_o, 8'h00);
        max_cnt = 0;
        log_q.delete();
        cycle(1, 8'h00, 0);
        for (int k = 1; k < 40; k++) cycle(1, 8'(k), 1);
        cycle(0, 8'h00, 1);
        chk("wrap_n", log_q.size(), 40);
        for (int k = 0; k < 40; k++) chk("wrap_byte", log_q[k], 8'(k));
        chk("wrap_max_count", max_cnt, 1);
`endif

        cycle(0, 8'h00, 0);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_uart_rx_fifo
`default_nettype wire
